// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an upstream synchronous FIFO and sends each one
// as an 8N1 UART frame (start bit, 8 data bits LSB first, stop bit).
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        baud_done;
    logic        frame_ready;

    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign frame_ready = enable && !fifo_empty;
    assign fifo_rd_en  = (state == FETCH);
    assign busy        = (state != IDLE);

    // tx is loaded on the edge that enters each bit, so the line level always matches the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            baud_cnt    <= 16'd0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'd0;
            tx          <= 1'b1;
            frame_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    if (frame_ready) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    baud_cnt <= 16'd0;
                    state    <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
                    baud_cnt  <= 16'd0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt    <= 16'd0;
                        frame_count <= frame_count + 16'd1;
                        state       <= frame_ready ? FETCH : IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= 16'd0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule
